// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider.
// Square wave plus one-cycle tick per channel; divisor swaps only at a period boundary.
module prog_clock_divider #(
  parameter  int N_CH    = 2,
  parameter  int CNT_W   = 16,
  parameter  int DEF_DIV = 4,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic [N_CH-1:0]       en,
  input  logic                  cfg_valid,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [CNT_W-1:0]      cfg_div,
  output logic                  cfg_err,
  output logic [N_CH-1:0]       pend,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       clk_out
);

  localparam logic [CH_W:0]    NCH  = (CH_W+1)'(N_CH);
  localparam logic [CNT_W-1:0] DEFV = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);

  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][CNT_W-1:0] div_q, div_d;
  logic [N_CH-1:0][CNT_W-1:0] pdiv_q, pdiv_d;
  logic [N_CH-1:0][CNT_W-1:0] dn_c;
  logic [N_CH-1:0]            pend_q, pend_d;
  logic [N_CH-1:0]            tick_q, tick_d;
  logic [N_CH-1:0]            clk_q, clk_d;
  logic [N_CH-1:0]            apply_c;
  logic [N_CH-1:0]            wr_c;
  logic                       err_q, err_d;
  logic                       bad_c;

  // Classify the config write and steer it to one channel.
  always_comb begin
    bad_c = (cfg_div < TWO) || ({1'b0, cfg_ch} >= NCH);
    err_d = cfg_valid && bad_c;
    wr_c  = '0;
    for (int c = 0; c < N_CH; c++) begin
      wr_c[c] = cfg_valid && !bad_c && (cfg_ch == CH_W'(c));
    end
  end

  // Per-channel counter, divisor swap at wrap or while disabled, pending write.
  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    pdiv_d  = pdiv_q;
    pend_d  = pend_q;
    tick_d  = tick_q;
    clk_d   = clk_q;
    apply_c = '0;
    dn_c    = div_q;
    for (int c = 0; c < N_CH; c++) begin
      if (!en[c]) begin
        cnt_d[c]   = '0;
        tick_d[c]  = 1'b0;
        apply_c[c] = pend_q[c];
      end else if (cnt_q[c] == div_q[c] - ONE) begin
        cnt_d[c]   = '0;
        tick_d[c]  = 1'b1;
        apply_c[c] = pend_q[c];
      end else begin
        cnt_d[c]   = cnt_q[c] + ONE;
        tick_d[c]  = 1'b0;
      end
      dn_c[c]   = apply_c[c] ? pdiv_q[c] : div_q[c];
      div_d[c]  = dn_c[c];
      pend_d[c] = pend_q[c] && !apply_c[c];
      clk_d[c]  = en[c] && (cnt_d[c] >= dn_c[c] - (dn_c[c] >> 1));
      if (wr_c[c]) begin
        pdiv_d[c] = cfg_div;
        pend_d[c] = 1'b1;
      end
    end
  end

  // State registers; reset restores the default divisor and drops pending writes.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      div_q  <= {N_CH{DEFV}};
      pdiv_q <= {N_CH{DEFV}};
      pend_q <= '0;
      tick_q <= '0;
      clk_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
      err_q  <= err_d;
    end
  end

  assign cfg_err = err_q;
  assign pend    = pend_q;
  assign tick    = tick_q;
  assign clk_out = clk_q;

endmodule
